// File: rtl/image_pkg.sv
// Shared definitions for the image BRAM arbiter: owner encoding, FSM states,
// default sizing and saturating-counter helpers.
package image_pkg;

  localparam int ADDR_W_DEF   = 16;
  localparam int DATA_W_DEF   = 8;
  localparam int BRAM_LAT_DEF = 1;
  localparam int MAX_WAIT_DEF = 15;

  localparam logic OWNER_DISP = 1'b0;
  localparam logic OWNER_ENG  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/tag_pipe.sv
// {valid, owner} shift register that tracks every BRAM access in flight so the
// read data can be steered to its requester when it leaves the BRAM.
module tag_pipe
  import image_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push_valid,
  input  logic i_push_owner,
  output logic o_tail_valid,
  output logic o_tail_owner,
  output logic o_empty
);

  tag_t [DEPTH-1:0] r_stage;

  // A new tag enters every cycle; idle cycles and writes insert a bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stage <= '0;
    end else begin
      r_stage[0].valid <= i_push_valid;
      r_stage[0].owner <= i_push_valid ? i_push_owner : OWNER_DISP;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  always_comb begin
    o_empty = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      o_empty = o_empty & ~r_stage[i].valid;
    end
  end

  assign o_tail_valid = r_stage[DEPTH-1].valid;
  assign o_tail_owner = r_stage[DEPTH-1].owner;

endmodule

// File: rtl/image_mem_arbiter.sv
// Single-port image BRAM arbiter: display reads have priority, the engine gets a
// forced slot once it has waited MAX_WAIT cycles; reads return in order.
module image_mem_arbiter
  import image_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int BRAM_LAT = BRAM_LAT_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic              o_disp_valid,
  output logic              o_disp_miss,
  output logic [DATA_W-1:0] o_disp_data,
  input  logic              i_eng_valid,
  output logic              o_eng_ready,
  input  logic              i_eng_we,
  input  logic [ADDR_W-1:0] i_eng_addr,
  input  logic [DATA_W-1:0] i_eng_wdata,
  output logic              o_eng_rvalid,
  output logic [DATA_W-1:0] o_eng_rdata,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic              o_bram_we,
  output logic [DATA_W-1:0] o_bram_din,
  input  logic [DATA_W-1:0] i_bram_dout,
  output logic [15:0]       o_miss_count,
  output logic              o_busy
);

  localparam int         TAG_DEPTH = 1 + BRAM_LAT;
  localparam logic [7:0] WAIT_THR  = 8'(MAX_WAIT);

  arb_state_e        r_state;
  arb_state_e        w_state_next;
  logic [7:0]        r_wait_cnt;
  logic              r_disp_miss;
  logic [15:0]       r_miss_count;
  logic [ADDR_W-1:0] r_bram_addr;
  logic              r_bram_we;
  logic [DATA_W-1:0] r_bram_din;

  logic w_active;
  logic w_starved;
  logic w_disp_grant;
  logic w_eng_grant;
  logic w_preempt;
  logic w_push_valid;
  logic w_push_owner;
  logic w_tail_valid;
  logic w_tail_owner;
  logic w_tag_empty;
  logic w_disp_valid;
  logic w_eng_rvalid;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state; DRAIN waits for all in-flight reads before going idle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   w_state_next = i_en ? ST_ACTIVE : ST_IDLE;
      ST_ACTIVE: w_state_next = i_en ? ST_ACTIVE : ST_DRAIN;
      ST_DRAIN: begin
        if (i_en) begin
          w_state_next = ST_ACTIVE;
        end else if (w_tag_empty) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DRAIN;
        end
      end
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Grant decision: display first unless the engine has been starved
  always_comb begin
    w_active     = (r_state == ST_ACTIVE) && i_en;
    w_starved    = i_eng_valid && (r_wait_cnt >= WAIT_THR);
    w_disp_grant = w_active && i_disp_req && !w_starved;
    w_eng_grant  = w_active && i_eng_valid && !w_disp_grant;
    w_preempt    = w_eng_grant && i_disp_req;
    w_push_valid = w_disp_grant || (w_eng_grant && !i_eng_we);
    w_push_owner = w_eng_grant ? OWNER_ENG : OWNER_DISP;
  end

  // Engine wait counter and display-miss bookkeeping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt   <= 8'd0;
      r_disp_miss  <= 1'b0;
      r_miss_count <= 16'd0;
    end else begin
      if (!i_eng_valid || w_eng_grant) begin
        r_wait_cnt <= 8'd0;
      end else begin
        r_wait_cnt <= sat_inc8(r_wait_cnt);
      end
      r_disp_miss <= w_preempt;
      if (w_preempt) begin
        r_miss_count <= sat_inc16(r_miss_count);
      end else begin
        r_miss_count <= r_miss_count;
      end
    end
  end

  // BRAM port registers; the address is held across idle cycles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bram_addr <= '0;
      r_bram_we   <= 1'b0;
      r_bram_din  <= '0;
    end else if (w_disp_grant) begin
      r_bram_addr <= i_disp_addr;
      r_bram_we   <= 1'b0;
    end else if (w_eng_grant) begin
      r_bram_addr <= i_eng_addr;
      r_bram_we   <= i_eng_we;
      r_bram_din  <= i_eng_wdata;
    end else begin
      r_bram_we   <= 1'b0;
    end
  end

  tag_pipe #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_pipe (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_push_valid (w_push_valid),
    .i_push_owner (w_push_owner),
    .o_tail_valid (w_tail_valid),
    .o_tail_owner (w_tail_owner),
    .o_empty      (w_tag_empty)
  );

  assign w_disp_valid = w_tail_valid && (w_tail_owner == OWNER_DISP);
  assign w_eng_rvalid = w_tail_valid && (w_tail_owner == OWNER_ENG);

  assign o_disp_valid = w_disp_valid;
  assign o_eng_rvalid = w_eng_rvalid;
  assign o_disp_data  = w_disp_valid ? i_bram_dout : '0;
  assign o_eng_rdata  = w_eng_rvalid ? i_bram_dout : '0;
  assign o_disp_miss  = r_disp_miss;
  assign o_eng_ready  = w_eng_grant;
  assign o_bram_addr  = r_bram_addr;
  assign o_bram_we    = r_bram_we;
  assign o_bram_din   = r_bram_din;
  assign o_miss_count = r_miss_count;
  assign o_busy       = (r_state != ST_IDLE);

endmodule
